// File: rtl/poco_pkg.sv
// Shared definitions for the small CPU datapath blocks.
// Holds the serial-adder state encoding and the default data width.
package poco_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake plus operand and result buses between the sequencer and the serial adder.
// The sequencer owns the master side and the adder owns the slave side.
interface serial_adder_if #(
    parameter int WIDTH = poco_pkg::DATA_W
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/full_add_cell.sv
// One-bit full adder, the only arithmetic element of the serial add path.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through a single full-add cell.
// Results, carry-out and signed overflow are registered and held until the next completion.
module serial_adder
    import poco_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    full_add_cell u_cell (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign sum_next = {cell_s, sum_sr[WIDTH-1:1]};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        accept     = bus.start && (state != ST_RUN);
        last       = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
        unique case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last)      state_next = ST_DONE;
            ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next == ST_RUN);
            done_r <= last;
            if (accept) begin
                op_a   <= bus.a;
                op_b   <= bus.b;
                carry  <= bus.cin;
                cnt    <= '0;
                sum_sr <= '0;
            end else if (state == ST_RUN) begin
                op_a   <= op_a >> 1;
                op_b   <= op_b >> 1;
                carry  <= cell_co;
                cnt    <= cnt + CNT_W'(1);
                sum_sr <= sum_next;
                // On the MSB cycle the carry flop still holds the carry into the MSB.
                if (last) begin
                    s_r    <= sum_next;
                    cout_r <= cell_co;
                    ovf_r  <= carry ^ cell_co;
                end
            end
        end
    end

    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule
